// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the two-port main-memory arbiter.
//   state_t   : arbiter FSM states
//   grant_t   : which requester owns the memory port
//   bytes4_t  : 4-lane byte bus, lane 0 is the most significant byte
//   pack_bytes / unpack_bytes : big-endian word <-> byte-lane conversion
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

  // Ascending lane range so that lane [0] is the leftmost (most significant)
  // byte of the packed vector.
  typedef logic [0:3][7:0] bytes4_t;

  function automatic bytes4_t pack_bytes(input logic [31:0] word);
    bytes4_t b;
    b[0] = word[31:24];
    b[1] = word[23:16];
    b[2] = word[15:8];
    b[3] = word[7:0];
    return b;
  endfunction

  function automatic logic [31:0] unpack_bytes(input bytes4_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
// Combinational two-requester round-robin picker.
//   req_i      : instruction-side request
//   req_d      : data-side request
//   last_grant : side served most recently
//   grant      : winner; a lone request wins, a tie goes to the side that
//                was not served last. Meaningless when neither requests.
// -----------------------------------------------------------------------------
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output grant_t grant
);

  // NOTE: a default assignment at the top of always_comb keeps every path
  // assigned, so no latch is inferred.
  always_comb begin
    grant = GNT_I;
    if (req_i && req_d) begin
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one fixed-latency main-memory port between the instruction-fetch
// cache and the data cache. One transaction at a time: grant in IDLE, drive
// the memory bus for MEM_LATENCY cycles in ACCESS, pulse ready in DONE.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   i_req/i_addr        : instruction read request (level, held until ready)
//   i_rdata/i_ready     : instruction read result and one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata : data request, read or write
//   d_rdata/d_ready     : data read result and one-cycle done pulse
//   address_output      : word-aligned memory address
//   write_en_out        : memory write enable (ACCESS of a write only)
//   mem_data_in         : byte lanes to memory, big-endian
//   mem_data_out        : byte lanes from memory, big-endian
// All outputs are registered; requests never reach the memory combinationally.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] address_output,
  output logic              write_en_out,
  output logic [0:3][7:0]   mem_data_in,
  input  logic [0:3][7:0]   mem_data_out
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t            state;
  grant_t            grant;
  grant_t            last_grant;
  grant_t            pick;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;

  arb_rr2 u_arb (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Instruction side always reads; only the data side can write.
  always_comb begin
    sel_we   = (pick == GNT_D) && d_we;
    sel_addr = (pick == GNT_D) ? d_addr : i_addr;
  end

  // NOTE: every register in this block uses non-blocking assignments so all
  // state updates see the pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= GNT_I;
      last_grant     <= GNT_I;
      we_q           <= 1'b0;
      cnt            <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      i_ready        <= 1'b0;
      d_ready        <= 1'b0;
      address_output <= '0;
      write_en_out   <= 1'b0;
      mem_data_in    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            // The bus registers are loaded here so they are already valid
            // in the first ACCESS cycle; they double as the request latch.
            grant          <= pick;
            we_q           <= sel_we;
            address_output <= sel_addr & ~ADDR_W'(3);
            write_en_out   <= sel_we;
            if (sel_we) begin
              mem_data_in <= pack_bytes(d_wdata);
            end
            cnt            <= CNT_W'(MEM_LATENCY - 1);
            state          <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (grant == GNT_D) begin
                d_rdata <= unpack_bytes(mem_data_out);
              end else begin
                i_rdata <= unpack_bytes(mem_data_out);
              end
            end
            // Ready is set here so its pulse lands in the DONE cycle.
            if (grant == GNT_D) begin
              d_ready <= 1'b1;
            end else begin
              i_ready <= 1'b1;
            end
            write_en_out <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter with MEM_LATENCY = 4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic [ADDR_W-1:0] address_output;
  logic              write_en_out;
  logic [0:3][7:0]   mem_data_in;
  logic [0:3][7:0]   mem_data_out;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .MEM_LATENCY (LAT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_ready        (i_ready),
    .d_req          (d_req),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_ready        (d_ready),
    .address_output (address_output),
    .write_en_out   (write_en_out),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " address_output"}, address_output, 32'h0);
    check({tag, " write_en_out"}, {31'b0, write_en_out}, 32'h0);
    check({tag, " mem_data_in"}, mem_data_in, 32'h0);
    check({tag, " i_rdata"}, i_rdata, 32'h0);
    check({tag, " d_rdata"}, d_rdata, 32'h0);
    check({tag, " i_ready"}, {31'b0, i_ready}, 32'h0);
    check({tag, " d_ready"}, {31'b0, d_ready}, 32'h0);
  endtask

  initial begin
    int cycles;

    reset        = 1'b1;
    i_req        = 1'b0;
    i_addr       = '0;
    d_req        = 1'b0;
    d_we         = 1'b0;
    d_addr       = '0;
    d_wdata      = '0;
    mem_data_out = '0;
    tick();
    tick();
    check_reset_outputs("reset");

    // ---------------- Single read ----------------
    reset        = 1'b0;
    d_req        = 1'b1;
    d_we         = 1'b0;
    d_addr       = 32'h0000_1004;
    mem_data_out = 32'hDEAD_BEEF;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check($sformatf("read addr c%0d", k), address_output, 32'h0000_1004);
      check($sformatf("read we c%0d", k), {31'b0, write_en_out}, 32'h0);
      check($sformatf("read no ready c%0d", k), {31'b0, d_ready}, 32'h0);
    end
    tick();
    check("read d_ready", {31'b0, d_ready}, 32'h1);
    check("read i_ready", {31'b0, i_ready}, 32'h0);
    check("read d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("read i_rdata", i_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    check("read ready drop", {31'b0, d_ready}, 32'h0);
    check("read addr hold", address_output, 32'h0000_1004);

    // ---------------- Write ----------------
    d_req        = 1'b1;
    d_we         = 1'b1;
    d_addr       = 32'h0000_2000;
    d_wdata      = 32'h1234_5678;
    mem_data_out = 32'h1122_3344;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check($sformatf("write we c%0d", k), {31'b0, write_en_out}, 32'h1);
      check($sformatf("write addr c%0d", k), address_output, 32'h0000_2000);
      check($sformatf("write data c%0d", k), mem_data_in, 32'h1234_5678);
    end
    check("write lane0", {24'b0, mem_data_in[0]}, 32'h12);
    check("write lane3", {24'b0, mem_data_in[3]}, 32'h78);
    tick();
    check("write we off", {31'b0, write_en_out}, 32'h0);
    check("write d_ready", {31'b0, d_ready}, 32'h1);
    check("write d_rdata kept", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check("write ready once", {31'b0, d_ready}, 32'h0);
    check("write data hold", mem_data_in, 32'h1234_5678);

    // ---------------- Simultaneous requests after reset ----------------
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    i_req        = 1'b1;
    i_addr       = 32'h0000_0103;
    d_req        = 1'b1;
    d_we         = 1'b0;
    d_addr       = 32'h0000_0300;
    mem_data_out = 32'hCAFE_F00D;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check($sformatf("tie1 D addr c%0d", k), address_output, 32'h0000_0300);
    end
    tick();
    check("tie1 d_ready", {31'b0, d_ready}, 32'h1);
    check("tie1 i_ready", {31'b0, i_ready}, 32'h0);
    check("tie1 d_rdata", d_rdata, 32'hCAFE_F00D);
    mem_data_out = 32'h0BAD_C0DE;
    tick();
    check("tie1 idle ready", {31'b0, d_ready | i_ready}, 32'h0);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check($sformatf("tie2 I unaligned addr c%0d", k), address_output, 32'h0000_0100);
    end
    tick();
    check("tie2 i_ready t+11", {31'b0, i_ready}, 32'h1);
    check("tie2 d_ready", {31'b0, d_ready}, 32'h0);
    check("tie2 i_rdata", i_rdata, 32'h0BAD_C0DE);
    check("tie2 d_rdata kept", d_rdata, 32'hCAFE_F00D);
    tick();
    tick();
    check("tie3 D addr", address_output, 32'h0000_0300);
    for (int k = 2; k <= LAT + 1; k++) tick();
    check("tie3 d_ready", {31'b0, d_ready}, 32'h1);
    check("tie3 i_ready", {31'b0, i_ready}, 32'h0);
    tick();
    tick();
    check("tie4 I addr", address_output, 32'h0000_0100);
    for (int k = 2; k <= LAT + 1; k++) tick();
    check("tie4 i_ready", {31'b0, i_ready}, 32'h1);
    check("tie4 d_ready", {31'b0, d_ready}, 32'h0);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // ---------------- Input changes mid-access ----------------
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0010;
    tick();
    check("midchg addr c1", address_output, 32'h0000_0010);
    d_addr = 32'h0000_0020;
    d_req  = 1'b0;
    for (int k = 2; k <= LAT; k++) begin
      tick();
      check($sformatf("midchg addr c%0d", k), address_output, 32'h0000_0010);
    end
    tick();
    check("midchg d_ready", {31'b0, d_ready}, 32'h1);
    tick();
    check("midchg ready once", {31'b0, d_ready}, 32'h0);
    tick();
    check("midchg no new access", address_output, 32'h0000_0010);

    // ---------------- Reset mid-access ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0040;
    d_wdata = 32'hA5A5_A5A5;
    tick();
    tick();
    check("rstmid we in access", {31'b0, write_en_out}, 32'h1);
    reset = 1'b1;
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    check_reset_outputs("rstmid");
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      check($sformatf("rstmid no ready %0d", k), {31'b0, d_ready | i_ready}, 32'h0);
    end

    i_req        = 1'b1;
    i_addr       = 32'h0000_0200;
    mem_data_out = 32'h1357_9BDF;
    cycles       = 0;
    while (!i_ready && cycles < 20) begin
      tick();
      cycles++;
    end
    check("post-reset i_ready latency", cycles, LAT + 1);
    check("post-reset i_rdata", i_rdata, 32'h1357_9BDF);
    check("post-reset addr", address_output, 32'h0000_0200);
    i_req = 1'b0;
    tick();
    check("post-reset ready once", {31'b0, i_ready}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
